move_controller: RTL
====================

// Module: move_controller
// PURPOSE
//  Sequences player movement on the maze grid. Turns direction-button requests into
//  one position update per press, and blocks moves off the grid or through the secret
//  west wall while that wall is closed.
//  Drives posx/posy and the enable_move pulse consumed by the key-discovery FSM.
//  Takes can_access_key back as wall_open_i.
// PARAMETERS
//  START_X       4'd0   posx after reset
//  START_Y       4'd0   posy after reset
//  GRID_X_MAX    4'd9   highest legal x
//  GRID_Y_MAX    4'd9   highest legal y
//  SECRET_X      4'd1   x of the cell whose west side is the secret wall
//  SECRET_Y      4'd6   y of that cell
//  COOLDOWN_CYC  16     lockout cycles after release (2_500_000 on board = 50 ms)
//  CW            22     cooldown counter width; must satisfy 2^CW > COOLDOWN_CYC
// PORTS
//  clk_50MHz_i     in   1  system clock, rising edge
//  rst_async_la_i  in   1  asynchronous reset, active low
//  btn_n_i         in   1  north request, synchronized level (y+1)
//  btn_s_i         in   1  south request (y-1)
//  btn_e_i         in   1  east request (x+1)
//  btn_w_i         in   1  west request (x-1)
//  wall_open_i     in   1  secret wall open (from key-discovery FSM)
//  posx_o          out  4  current x
//  posy_o          out  4  current y
//  enable_move_o   out  1  1-cycle pulse per granted attempt (blocked ones included)
//  moved_o         out  1  1-cycle pulse when position actually changed
//  blocked_o       out  1  1-cycle pulse when a granted attempt was refused
//  dir_o           out  2  direction of last grant: N=0 E=1 S=2 W=3
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, posx_o=START_X, posy_o=START_Y,
//    all pulses 0, dir_o=0, cooldown count=0.
//  - States:
//    IDLE: any btn high -> CHECK; grant by fixed priority N>E>S>W; latch dir.
//    CHECK: compute target; blocked if any of:
//      . N with y==GRID_Y_MAX
//      . S with y==0
//      . E with x==GRID_X_MAX
//      . W with x==0
//      . W from (SECRET_X,SECRET_Y) while wall_open_i==0 (sampled this cycle)
//      Always -> COMMIT.
//    COMMIT: one cycle.
//      . enable_move_o=1.
//      . If legal: moved_o=1 and posx/posy hold the new value from this cycle on.
//      . If blocked: blocked_o=1, position unchanged.
//      Always -> RELEASE.
//    RELEASE: wait until all four btn low -> COOLDOWN. Held buttons never repeat.
//    COOLDOWN: count COOLDOWN_CYC cycles; btn ignored -> IDLE at terminal count.
//  - Latency: btn high in IDLE at edge k -> CHECK at k+1 -> COMMIT (pulses, new pos)
//    at k+2.
//  - Registered outputs: pulses are high exactly during the COMMIT cycle.
//    enable_move_o and (moved_o XOR blocked_o) are high together.
//  - Simultaneous buttons: only the highest-priority one is served; the rest are
//    dropped, not queued.
//  - Arithmetic: 4-bit unsigned; no wrap-around is possible because boundary moves
//    are blocked.
//  - wall_open_i changing outside CHECK has no effect on a decision already made.
//  - Reset mid-operation (any state, incl. COMMIT): position returns to START,
//    no pulse is emitted.
// STRUCTURE
//  - Shared include zork_defs.vh:
//    . direction codes DIR_N/E/S/W
//    . state codes IDLE/CHECK/COMMIT/RELEASE/COOLDOWN (3-bit)
//    . grid constants
//  - Three always blocks: next-state, state/position regs, output decode.
//  - One sub-module move_cooldown_timer (params N, DW):
//    . ports start_i, clk_50MHz_i, rst_async_la_i, done_o.
//    . done_o is a 1-cycle pulse N cycles after start_i.
// TESTING (COOLDOWN_CYC=4, START 0,0)
//  1. E press from (0,0), held 10 cycles -> exactly one enable_move_o and moved_o;
//     posx=1 two cycles after press; no repeat until release + 4 cycles.
//  2. N+E+W together at (3,3) -> dir_o=N, posy=4, posx unchanged; only one pulse.
//  3. W at (0,5); S at (2,0); E at (9,2) -> blocked_o and enable_move_o each time,
//     moved_o=0, position unchanged.
//  4. At (1,6), wall_open_i=0, two W presses -> two enable_move_o, two blocked_o;
//     then wall_open_i=1, W -> moved_o, pos (0,6).
//  5. Press during COOLDOWN (cycle 2 of 4) and released before IDLE -> ignored;
//     same press held into IDLE -> served.
//  6. rst_async_la_i low for 1 cycle during COMMIT -> pos (0,0), all pulses 0
//     immediately; a fresh press then works.

Source files
------------

// File: rtl/move_controller_pkg.sv
// Shared direction/state encodings and grid defaults for the maze movement controller.
// No logic beyond a pure combinational priority helper.
// No flow control; consumers register whatever they derive from these definitions.
package move_controller_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_e;

    localparam logic [3:0] GRID_X_MAX_DEF = 4'd9;
    localparam logic [3:0] GRID_Y_MAX_DEF = 4'd9;
    localparam logic [3:0] SECRET_X_DEF   = 4'd1;
    localparam logic [3:0] SECRET_Y_DEF   = 4'd6;

    // req = {n, e, s, w}; fixed priority N > E > S > W, lower requests are dropped.
    function automatic dir_e grant_dir(input logic [3:0] req);
        dir_e d;
        if (req[3])      d = DIR_N;
        else if (req[2]) d = DIR_E;
        else if (req[1]) d = DIR_S;
        else             d = DIR_W;
        return d;
    endfunction

endpackage

// File: rtl/move_controller_cooldown_timer.sv
// One-shot lockout timer: done_o pulses for one cycle exactly N cycles after start_i.
// Latency N cycles from start_i; a new start_i restarts the count.
// No backpressure; start_i is assumed to be a single-cycle request.
module move_cooldown_timer #(
    parameter int N  = 16,
    parameter int DW = 22
) (
    input  logic clk_50MHz_i,
    input  logic rst_async_la_i,
    input  logic start_i,
    output logic done_o
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = DW'(N);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == DW'(1));

endmodule

// File: rtl/move_controller.sv
// Turns direction-button presses into one legal grid step each, refusing edge and closed-wall moves.
// Press sampled at edge k -> decision at k+1 -> registered pulses and new position at k+2.
// Held buttons never repeat: a full release plus COOLDOWN_CYC idle cycles is required between grants.
module move_controller
    import move_controller_pkg::*;
#(
    parameter logic [3:0] START_X      = 4'd0,
    parameter logic [3:0] START_Y      = 4'd0,
    parameter logic [3:0] GRID_X_MAX   = GRID_X_MAX_DEF,
    parameter logic [3:0] GRID_Y_MAX   = GRID_Y_MAX_DEF,
    parameter logic [3:0] SECRET_X     = SECRET_X_DEF,
    parameter logic [3:0] SECRET_Y     = SECRET_Y_DEF,
    parameter int         COOLDOWN_CYC = 16,
    parameter int         CW           = 22
) (
    input  logic       clk_50MHz_i,
    input  logic       rst_async_la_i,
    input  logic       btn_n_i,
    input  logic       btn_s_i,
    input  logic       btn_e_i,
    input  logic       btn_w_i,
    input  logic       wall_open_i,
    output logic [3:0] posx_o,
    output logic [3:0] posy_o,
    output logic       enable_move_o,
    output logic       moved_o,
    output logic       blocked_o,
    output logic [1:0] dir_o
);

    state_e     state_q, state_d;
    logic [3:0] posx_q, posx_d;
    logic [3:0] posy_q, posy_d;
    dir_e       dir_q, dir_d;
    logic       enable_move_q, enable_move_d;
    logic       moved_q, moved_d;
    logic       blocked_q, blocked_d;

    logic [3:0] btn_req;
    logic       any_btn;
    logic       cd_start;
    logic       cd_done;
    logic       blocked;
    logic [3:0] tgt_x;
    logic [3:0] tgt_y;

    assign btn_req  = {btn_n_i, btn_e_i, btn_s_i, btn_w_i};
    assign any_btn  = |btn_req;
    assign cd_start = (state_q == ST_RELEASE) && !any_btn;

    move_cooldown_timer #(
        .N  (COOLDOWN_CYC),
        .DW (CW)
    ) u_cooldown (
        .clk_50MHz_i    (clk_50MHz_i),
        .rst_async_la_i (rst_async_la_i),
        .start_i        (cd_start),
        .done_o         (cd_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (any_btn) state_d = ST_CHECK;
            ST_CHECK:    state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_RELEASE;
            ST_RELEASE:  if (!any_btn) state_d = ST_COOLDOWN;
            ST_COOLDOWN: if (cd_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Wall state is only looked at here, in CHECK; later changes cannot alter the decision.
    always_comb begin
        tgt_x   = posx_q;
        tgt_y   = posy_q;
        blocked = 1'b0;
        case (dir_q)
            DIR_N: begin
                blocked = (posy_q == GRID_Y_MAX);
                tgt_y   = posy_q + 4'd1;
            end
            DIR_E: begin
                blocked = (posx_q == GRID_X_MAX);
                tgt_x   = posx_q + 4'd1;
            end
            DIR_S: begin
                blocked = (posy_q == 4'd0);
                tgt_y   = posy_q - 4'd1;
            end
            default: begin
                blocked = (posx_q == 4'd0) ||
                          ((posx_q == SECRET_X) && (posy_q == SECRET_Y) && !wall_open_i);
                tgt_x   = posx_q - 4'd1;
            end
        endcase
    end

    always_comb begin
        posx_d        = posx_q;
        posy_d        = posy_q;
        dir_d         = dir_q;
        enable_move_d = 1'b0;
        moved_d       = 1'b0;
        blocked_d     = 1'b0;
        if (state_q == ST_IDLE && any_btn) begin
            dir_d = grant_dir(btn_req);
        end
        if (state_q == ST_CHECK) begin
            enable_move_d = 1'b1;
            if (blocked) begin
                blocked_d = 1'b1;
            end else begin
                moved_d = 1'b1;
                posx_d  = tgt_x;
                posy_d  = tgt_y;
            end
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state_q       <= ST_IDLE;
            posx_q        <= START_X;
            posy_q        <= START_Y;
            dir_q         <= DIR_N;
            enable_move_q <= 1'b0;
            moved_q       <= 1'b0;
            blocked_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            posx_q        <= posx_d;
            posy_q        <= posy_d;
            dir_q         <= dir_d;
            enable_move_q <= enable_move_d;
            moved_q       <= moved_d;
            blocked_q     <= blocked_d;
        end
    end

    assign posx_o        = posx_q;
    assign posy_o        = posy_q;
    assign enable_move_o = enable_move_q;
    assign moved_o       = moved_q;
    assign blocked_o     = blocked_q;
    assign dir_o         = dir_q;

endmodule
